// File: rtl/mem_store_buffer_if.sv
// Store-buffer bus bundle: MEM-stage store request, same-cycle load probe, DM write port.
// Latency: none (wires only).
// Backpressure: st_valid/st_ready on the store side; ld_conflict asks the MEM stage to stall.
// Ports (slave = buffer side):
//   st_valid/st_ready/st_addr/st_data/st_type/st_pc  store request from MEM stage
//   ld_valid/ld_addr/ld_type -> ld_hit/ld_data/ld_conflict  load forwarding probe
//   dm_we/dm_addr/dm_data/dm_type/dm_pc  drain into the data memory write port
//   sb_empty  no pending stores
interface mem_store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_type;
  logic [31:0] st_pc;

  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_type;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_conflict;

  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_data;
  logic [1:0]  dm_type;
  logic [31:0] dm_pc;

  logic        sb_empty;

  modport slave (
    input  st_valid, st_addr, st_data, st_type, st_pc,
    output st_ready,
    input  ld_valid, ld_addr, ld_type,
    output ld_hit, ld_data, ld_conflict,
    output dm_we, dm_addr, dm_data, dm_type, dm_pc,
    output sb_empty
  );

  modport master (
    output st_valid, st_addr, st_data, st_type, st_pc,
    input  st_ready,
    output ld_valid, ld_addr, ld_type,
    input  ld_hit, ld_data, ld_conflict,
    input  dm_we, dm_addr, dm_data, dm_type, dm_pc,
    input  sb_empty
  );
endinterface

// File: rtl/mem_store_buffer.sv
// FIFO store buffer in front of the data memory; forwards pending store data to same-cycle loads.
// Latency: a store accepted at edge N can drive dm_we from the cycle after edge N; no empty bypass.
// Backpressure: st_ready drops when full (even if draining); drain pauses while a load owns DM.
// Ports:
//   clk   clock, all state on posedge
//   rst   asynchronous active-low reset
//   bus   mem_store_buffer_if.slave (store request, load probe, DM write port, sb_empty)
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 12
) (
  input logic               clk,
  input logic               rst,
  mem_store_buffer_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_byte;
    logic [31:0] pc;
  } entry_t;

  entry_t        ent [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          st_ready;
  logic          push;
  logic          drain;

  logic          fwd_found;
  entry_t        fwd_ent;
  logic [PW-1:0] scan_idx;

  logic          ld_hit;
  logic          ld_conflict;
  logic [31:0]   ld_data;

  // Upper load address bits do not take part in matching (DM aliases them).
  logic          unused_ld_addr;
  assign unused_ld_addr = ^bus.ld_addr[31:AW];

  // Readiness comes from the registered count only, so a full buffer never
  // accepts a push on the strength of a same-cycle drain.
  assign st_ready = (count != FULL);
  assign push     = bus.st_valid && st_ready;

  // Scan oldest to youngest; the last match seen is the youngest one.
  always_comb begin
    fwd_found = 1'b0;
    fwd_ent   = '0;
    scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if ((CW'(i) < count) &&
          (ent[scan_idx].addr[AW-1:2] == bus.ld_addr[AW-1:2])) begin
        fwd_found = 1'b1;
        fwd_ent   = ent[scan_idx];
      end
    end
  end

  always_comb begin
    ld_hit      = 1'b0;
    ld_conflict = 1'b0;
    ld_data     = '0;
    if (bus.ld_valid && fwd_found) begin
      if (!fwd_ent.is_byte) begin
        ld_hit = 1'b1;
        if (!bus.ld_type) begin
          ld_data = fwd_ent.data;
        end else begin
          ld_data = {24'b0, fwd_ent.data[{bus.ld_addr[1:0], 3'b000} +: 8]};
        end
      end else if (bus.ld_type && (fwd_ent.addr[1:0] == bus.ld_addr[1:0])) begin
        ld_hit  = 1'b1;
        ld_data = {24'b0, fwd_ent.data[7:0]};
      end else begin
        // Partial overlap: only DM can merge it, so the load must wait for the drain.
        ld_conflict = 1'b1;
      end
    end
  end

  // A served or non-overlapping load uses the DM address port this cycle.
  // A conflicting load must let the drain run or it would never resolve.
  assign drain = (count != '0) && (!bus.ld_valid || ld_conflict);

  assign bus.st_ready    = st_ready;
  assign bus.sb_empty    = (count == '0);
  assign bus.ld_hit      = ld_hit;
  assign bus.ld_conflict = ld_conflict;
  assign bus.ld_data     = ld_data;

  assign bus.dm_we   = drain;
  assign bus.dm_addr = drain ? ent[head].addr : '0;
  assign bus.dm_data = drain ? ent[head].data : '0;
  assign bus.dm_type = drain ? {1'b0, ent[head].is_byte} : 2'b00;
  assign bus.dm_pc   = drain ? ent[head].pc : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else begin
      if (push) begin
        ent[tail].addr    <= bus.st_addr;
        ent[tail].data    <= bus.st_data;
        ent[tail].is_byte <= bus.st_type;
        ent[tail].pc      <= bus.st_pc;
        tail              <= tail + 1'b1;
      end
      if (drain) begin
        head <= head + 1'b1;
      end
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: expected DM writes and load responses are queued
// as stimulus is issued; a negedge monitor pops and compares whenever the DUT writes DM
// or a load is presented.
module tb_mem_store_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_store_buffer_if bus();

  mem_store_buffer #(.DEPTH(4), .AW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  typ;
    logic [31:0] pc;
  } dm_exp_t;

  typedef struct packed {
    logic        hit;
    logic        conflict;
    logic [31:0] data;
    logic        we;
  } ld_exp_t;

  dm_exp_t dmq[$];
  ld_exp_t ldq[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every DM write and every presented load against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.dm_we) begin
        if (dmq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL dm_unexpected: got write addr %h data %h, expected none (t=%0t)",
                   bus.dm_addr, bus.dm_data, $time);
        end else begin
          dm_exp_t e;
          e = dmq.pop_front();
          check("dm_addr", bus.dm_addr, e.addr);
          check("dm_data", bus.dm_data, e.data);
          check("dm_type", {30'b0, bus.dm_type}, {30'b0, e.typ});
          check("dm_pc",   bus.dm_pc,   e.pc);
        end
      end
      if (bus.ld_valid) begin
        if (ldq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL ld_unexpected: got load at %h, expected none (t=%0t)", bus.ld_addr, $time);
        end else begin
          ld_exp_t l;
          l = ldq.pop_front();
          check("ld_hit",      {31'b0, bus.ld_hit},      {31'b0, l.hit});
          check("ld_conflict", {31'b0, bus.ld_conflict}, {31'b0, l.conflict});
          check("ld_dm_we",    {31'b0, bus.dm_we},       {31'b0, l.we});
          if (l.hit) check("ld_data", bus.ld_data, l.data);
        end
      end
    end
  end

  // Present a store until accepted; queue its DM write once accepted.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic t,
                          input logic [31:0] pc);
    int   n = 0;
    logic rdy = 1'b0;
    dm_exp_t e;
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_type  = t;
    bus.st_pc    = pc;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = bus.st_ready;
      @(posedge clk);
      n++;
    end
    #1;
    bus.st_valid = 1'b0;
    if (!rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL store_accept: got no st_ready for %h, expected accept within 50 cycles", a);
    end else begin
      e.addr = a;
      e.data = d;
      e.typ  = {1'b0, t};
      e.pc   = pc;
      dmq.push_back(e);
    end
  endtask

  // Present a load for exactly one cycle with its expected response.
  task automatic do_load(input logic [31:0] a, input logic t, input logic hit, input logic conf,
                         input logic [31:0] d, input logic we);
    ld_exp_t l;
    l.hit      = hit;
    l.conflict = conf;
    l.data     = d;
    l.we       = we;
    ldq.push_back(l);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_type  = t;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_type  = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!bus.sb_empty && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (!bus.sb_empty) begin
      n_err++;
      $display("FAIL drain_timeout: got sb_empty 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.st_type  = 1'b0;
    bus.st_pc    = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_type  = 1'b0;

    // Reset state
    #12;
    check("rst_st_ready", {31'b0, bus.st_ready},    32'd1);
    check("rst_sb_empty", {31'b0, bus.sb_empty},    32'd1);
    check("rst_dm_we",    {31'b0, bus.dm_we},       32'd0);
    check("rst_dm_addr",  bus.dm_addr,              32'd0);
    check("rst_ld_hit",   {31'b0, bus.ld_hit},      32'd0);
    check("rst_ld_conf",  {31'b0, bus.ld_conflict}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-drain: 3 stores held behind non-matching loads, one drains, then reset.
    fork
      begin
        do_store(32'h40, 32'h0000_0040, 1'b0, 32'h1000);
        do_store(32'h44, 32'h0000_0044, 1'b0, 32'h1004);
        do_store(32'h48, 32'h0000_0048, 1'b0, 32'h1008);
      end
      repeat (3) do_load(32'h800, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    join
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_sb_empty", {31'b0, bus.sb_empty}, 32'd1);
    check("mid_rst_dm_we",    {31'b0, bus.dm_we},    32'd0);
    check("mid_rst_st_ready", {31'b0, bus.st_ready}, 32'd1);
    check("mid_rst_undrained", dmq.size(), 32'd2);
    dmq.delete();
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Fill/full: loads with no match block the drain while 4 stores fill it.
    fork
      begin
        for (int i = 0; i < 4; i++)
          do_store(32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 32'h2000 + 32'(4 * i));
        @(negedge clk);
        check("full_st_ready", {31'b0, bus.st_ready}, 32'd0);
        check("full_sb_empty", {31'b0, bus.sb_empty}, 32'd0);
        do_store(32'h10, 32'hA000_0004, 1'b0, 32'h2010);
      end
      repeat (6) do_load(32'h800, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    join
    wait_empty();

    // Word forward
    do_store(32'h100, 32'hDEAD_BEEF, 1'b0, 32'h3000);
    do_load(32'h100, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    wait_empty();

    // Byte from word, AW aliasing, non-overlapping load
    do_store(32'h200, 32'h1122_3344, 1'b0, 32'h3100);
    do_load(32'h202,  1'b1, 1'b1, 1'b0, 32'h0000_0022, 1'b0);
    do_load(32'h1200, 1'b0, 1'b1, 1'b0, 32'h1122_3344, 1'b0);
    do_load(32'h204,  1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    wait_empty();

    // Youngest wins; conflicts drain until no match remains
    fork
      begin
        do_store(32'h300, 32'hAAAA_AAAA, 1'b0, 32'h3200);
        do_store(32'h301, 32'h9988_7755, 1'b1, 32'h3204);
      end
      repeat (2) do_load(32'h900, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    join
    do_load(32'h301, 1'b1, 1'b1, 1'b0, 32'h0000_0055, 1'b0);
    do_load(32'h302, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    do_load(32'h300, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    do_load(32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    wait_empty();

    // Simultaneous push and drain at count 2, wrapping the pointers
    fork
      begin
        do_store(32'h1000, 32'hC000_0000, 1'b0, 32'h4000);
        do_store(32'h1004, 32'hC000_0001, 1'b0, 32'h4004);
      end
      repeat (2) do_load(32'h900, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    join
    for (int i = 0; i < 10; i++)
      do_store(32'h1008 + 32'(4 * i), 32'hC000_0002 + 32'(i), 1'b0, 32'h4008 + 32'(4 * i));
    @(posedge clk);
    #1;
    check("pd_one_left", {31'b0, bus.sb_empty}, 32'd0);
    @(posedge clk);
    #1;
    check("pd_empty", {31'b0, bus.sb_empty}, 32'd1);
    wait_empty();

    repeat (3) @(posedge clk);
    #1;
    check("dm_queue_left", dmq.size(), 32'd0);
    check("ld_queue_left", ldq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
